// File: rtl/amb_core.sv
// amb_core: single-cycle accumulator-machine CPU core.
// Ports: clk/rst (sync, active-high); opcode/operand from async imem at pc;
//        ddatain from async dmem at operand; pc, accum (dmem write data), we.
module amb_core #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int OPCODE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [ADDR_W-1:0]   operand,
  input  logic [DATA_W-1:0]   ddatain,
  output logic [ADDR_W-1:0]   pc,
  output logic [DATA_W-1:0]   accum,
  output logic                we
);

  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(4'h0);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(4'h1);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(4'h2);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(4'h3);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(4'h4);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(4'h5);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(4'h6);
  localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(4'h7);
  localparam logic [OPCODE_W-1:0] OP_NOT  = OPCODE_W'(4'h8);
  localparam logic [OPCODE_W-1:0] OP_SHL  = OPCODE_W'(4'h9);
  localparam logic [OPCODE_W-1:0] OP_SHR  = OPCODE_W'(4'hA);
  localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(4'hB);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(4'hC);
  localparam logic [OPCODE_W-1:0] OP_BEZ  = OPCODE_W'(4'hD);
  localparam logic [OPCODE_W-1:0] OP_BNZ  = OPCODE_W'(4'hE);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(4'hF);

  logic [DATA_W-1:0] acc_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;

  // Natural ADDR_W-bit overflow gives the wrap from the top address to 0.
  assign pc_inc = pc + ADDR_W'(1);

  always_comb begin
    acc_nxt = accum;
    pc_nxt  = pc_inc;
    we      = 1'b0;
    case (opcode)
      OP_NOP:  ;
      OP_LD:   acc_nxt = ddatain;
      OP_ST:   we      = 1'b1;
      OP_ADD:  acc_nxt = accum + ddatain;
      OP_SUB:  acc_nxt = accum - ddatain;
      OP_AND:  acc_nxt = accum & ddatain;
      OP_OR:   acc_nxt = accum | ddatain;
      OP_XOR:  acc_nxt = accum ^ ddatain;
      OP_NOT:  acc_nxt = ~accum;
      OP_SHL:  acc_nxt = {accum[DATA_W-2:0], 1'b0};
      OP_SHR:  acc_nxt = {1'b0, accum[DATA_W-1:1]};
      OP_LDI:  acc_nxt = DATA_W'(operand);
      OP_JMP:  pc_nxt  = operand;
      // Branches test the accumulator as it stands before this edge.
      OP_BEZ:  if (accum == '0) pc_nxt = operand;
      OP_BNZ:  if (accum != '0) pc_nxt = operand;
      OP_HALT: pc_nxt  = pc;
      default: ;
    endcase
    // A reset edge aborts the instruction, so the store must not reach memory.
    if (rst) we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      accum <= '0;
    end else begin
      pc    <= pc_nxt;
      accum <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_amb_core.sv
// tb_amb_core: bench for amb_core with behavioural async imem/dmem models.
// Expected (pc, accum) per cycle are queued as each program is set up and
// popped/compared one per clock as the core executes.
module tb_amb_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  opcode;
  logic [7:0]  operand;
  logic [15:0] ddatain;
  logic [7:0]  pc;
  logic [15:0] accum;
  logic        we;

  logic [11:0] imem [256];
  logic [15:0] dmem [256];

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] acc;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  amb_core #(.DATA_W(16), .ADDR_W(8), .OPCODE_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .operand (operand),
    .ddatain (ddatain),
    .pc      (pc),
    .accum   (accum),
    .we      (we)
  );

  always #5 clk = ~clk;

  assign opcode  = imem[pc][11:8];
  assign operand = imem[pc][7:0];
  assign ddatain = dmem[operand];

  always @(posedge clk) begin
    if (we) dmem[operand] <= accum;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = 12'hF00;
  endtask

  task automatic exp_push(input logic [7:0] epc, input logic [15:0] eacc);
    exp_t e;
    e.pc  = epc;
    e.acc = eacc;
    sb.push_back(e);
  endtask

  // Two reset edges; outputs checked while rst is still high.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_rst_pc"},  32'(pc),    32'h0);
    chk({tag, "_rst_acc"}, 32'(accum), 32'h0);
    chk({tag, "_rst_we"},  32'(we),    32'h0);
    rst = 1'b0;
  endtask

  // One edge per queued expectation; bounded by the queue length.
  task automatic drain(input string tag);
    exp_t e;
    int cyc = 0;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("%s_c%0d_pc", tag, cyc),  32'(pc),    32'(e.pc));
      chk($sformatf("%s_c%0d_acc", tag, cyc), 32'(accum), 32'(e.acc));
      cyc++;
    end
  endtask

  // LD from ld_addr, apply op_word, then HALT.
  task automatic run_alu(input string tag, input logic [7:0] ld_addr,
                         input logic [15:0] ld_val, input logic [11:0] op_word,
                         input logic [15:0] exp_acc);
    clear_prog();
    imem[0] = {4'h1, ld_addr};
    imem[1] = op_word;
    do_reset(tag);
    exp_push(8'h01, ld_val);
    exp_push(8'h02, exp_acc);
    exp_push(8'h02, exp_acc);
    drain(tag);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 256; i++) dmem[i] = 16'h0;
    clear_prog();

    // Reset with a store at address 0: no write may happen while in reset.
    imem[0] = 12'h205;
    dmem[5] = 16'h1234;
    do_reset("reset");
    rst = 1'b1;
    chk("reset_st_we", 32'(we), 32'h0);
    imem[0] = 12'h000;
    @(posedge clk);
    #1;
    chk("reset_no_store", 32'(dmem[5]), 32'h1234);
    rst = 1'b0;
    exp_push(8'h01, 16'h0000);
    drain("reset_nop");

    // Load / add / store / halt.
    clear_prog();
    dmem[0] = 16'h0003;
    dmem[1] = 16'h0005;
    dmem[2] = 16'h0000;
    imem[0] = 12'h100;
    imem[1] = 12'h301;
    imem[2] = 12'h202;
    do_reset("ldst");
    exp_push(8'h01, 16'h0003);
    exp_push(8'h02, 16'h0008);
    exp_push(8'h03, 16'h0008);
    for (int i = 0; i < 5; i++) exp_push(8'h03, 16'h0008);
    drain("ldst");
    chk("ldst_dmem2", 32'(dmem[2]), 32'h0008);

    // ALU operations.
    dmem[0] = 16'h00F0;
    dmem[1] = 16'h000F;
    dmem[2] = 16'h8001;
    run_alu("sub", 8'h00, 16'h00F0, 12'h401, 16'h00E1);
    run_alu("and", 8'h00, 16'h00F0, 12'h501, 16'h0000);
    run_alu("or",  8'h00, 16'h00F0, 12'h601, 16'h00FF);
    run_alu("xor", 8'h00, 16'h00F0, 12'h701, 16'h00FF);
    run_alu("not", 8'h00, 16'h00F0, 12'h800, 16'hFF0F);
    run_alu("shl", 8'h02, 16'h8001, 12'h900, 16'h0002);
    run_alu("shr", 8'h02, 16'h8001, 12'hA00, 16'h4000);

    // Modular add, then BEZ taken and BNZ not taken.
    clear_prog();
    dmem[0] = 16'hFFFF;
    dmem[1] = 16'h0001;
    imem[0]     = 12'h100;
    imem[1]     = 12'h301;
    imem[2]     = 12'hD10;
    imem[8'h10] = 12'hE40;
    do_reset("wrap");
    exp_push(8'h01, 16'hFFFF);
    exp_push(8'h02, 16'h0000);
    exp_push(8'h10, 16'h0000);
    exp_push(8'h11, 16'h0000);
    exp_push(8'h11, 16'h0000);
    drain("wrap");

    // Countdown loop: three passes through address 1.
    clear_prog();
    dmem[5] = 16'h0001;
    imem[0] = 12'hB03;
    imem[1] = 12'h405;
    imem[2] = 12'hE01;
    do_reset("loop");
    exp_push(8'h01, 16'h0003);
    exp_push(8'h02, 16'h0002);
    exp_push(8'h01, 16'h0002);
    exp_push(8'h02, 16'h0001);
    exp_push(8'h01, 16'h0001);
    exp_push(8'h02, 16'h0000);
    exp_push(8'h03, 16'h0000);
    exp_push(8'h03, 16'h0000);
    drain("loop");

    // LDI zero-extension, JMP to the top address, pc wrap, BEZ not taken.
    clear_prog();
    imem[0]     = 12'hBAB;
    imem[1]     = 12'hCFF;
    imem[8'hFF] = 12'h000;
    do_reset("pcwrap");
    exp_push(8'h01, 16'h00AB);
    exp_push(8'hFF, 16'h00AB);
    exp_push(8'h00, 16'h00AB);
    exp_push(8'h01, 16'h00AB);
    drain("pcwrap");
    clear_prog();
    imem[0] = 12'hB01;
    imem[1] = 12'hD20;
    do_reset("beznt");
    exp_push(8'h01, 16'h0001);
    exp_push(8'h02, 16'h0001);
    exp_push(8'h02, 16'h0001);
    drain("beznt");

    // Reset asserted during a store cycle.
    clear_prog();
    dmem[9] = 16'h5555;
    imem[0] = 12'hB07;
    imem[1] = 12'h209;
    do_reset("midrst");
    exp_push(8'h01, 16'h0007);
    drain("midrst");
    chk("midrst_st_we_pre", 32'(we), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_we", 32'(we), 32'h0);
    @(posedge clk);
    #1;
    chk("midrst_pc",   32'(pc),      32'h0);
    chk("midrst_acc",  32'(accum),   32'h0);
    chk("midrst_dmem", 32'(dmem[9]), 32'h5555);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/amb_core.md
# amb_core

Single-cycle accumulator-machine CPU core (block `amb`). Each clock it fetches one instruction from an external asynchronous-read instruction memory addressed by `pc`. It executes the instruction against a single accumulator register and an external asynchronous-read data memory, then updates `pc`. Instruction and data memories live outside the block; the core only drives addresses, write data and write enable.

## Interface
Parameters:
- `DATA_W`, 16: accumulator and data-memory word width.
- `ADDR_W`, 8: `pc`, operand and memory address width; memory depth is 2^ADDR_W.
- `OPCODE_W`, 4: opcode field width; instruction width = OPCODE_W+ADDR_W, with the opcode in the MSBs.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `opcode`, in, OPCODE_W: opcode field of the instruction at `pc` (combinational from imem).
- `operand`, in, ADDR_W: operand field; used as the data address, immediate or jump target.
- `ddatain`, in, DATA_W: data-memory read data at address `operand` (combinational).
- `pc`, out, ADDR_W: program counter, registered; the instruction-memory address.
- `accum`, out, DATA_W: accumulator, registered; also the data-memory write data.
- `we`, out, 1: data-memory write enable, combinational; memory writes `accum` to `operand` on the rising edge while `we`=1.

## Operation
Opcodes (hex), effect on `acc`/`pc`; unless stated, pc <= pc+1:
- 0 NOP: no change.
- 1 LD: acc <= ddatain.
- 2 ST: we=1; acc unchanged.
- 3 ADD: acc <= acc+ddatain.
- 4 SUB: acc <= acc-ddatain.
- 5 AND: acc <= acc & ddatain.
- 6 OR: acc <= acc | ddatain.
- 7 XOR: acc <= acc ^ ddatain.
- 8 NOT: acc <= ~acc.
- 9 SHL: acc <= acc<<1, LSB filled with 0.
- A SHR: acc <= acc>>1, logical, MSB filled with 0.
- B LDI: acc <= zero-extended operand.
- C JMP: pc <= operand.
- D BEZ: pc <= operand if acc==0, else pc+1.
- E BNZ: pc <= operand if acc!=0, else pc+1.
- F HALT: pc and acc hold indefinitely, until reset.

Arithmetic rules:
- All arithmetic is modulo 2^DATA_W; no carry or overflow flags.
- Branch conditions test the acc value before the current edge.

Enable and wrap rules:
- we = (opcode==ST) && !rst. It is never asserted for any other opcode or during reset.
- pc increment wraps from 2^ADDR_W-1 to 0.

## Timing
- Reset: while `rst`=1 at a rising edge, pc <= 0 and acc <= 0. Outputs read pc=0, acc=0 after the first reset edge. `we`=0 throughout reset.
- Reset asserted mid-program aborts the current instruction: no acc update, no store, pc goes to 0.
- Latency: one instruction per cycle.
  - An instruction's acc/pc results are visible after the rising edge that ends its cycle.
  - A following LD/ADD sees data written by a preceding ST, because the memory updates on the same edge.
- ST writes the acc value present before the edge. An ST immediately after LD stores the loaded value.
- No handshakes and no stalls. Inputs must settle combinationally within the cycle (`opcode`/`operand` from pc, `ddatain` from operand).
- HALT is a steady state: pc is constant and acc is constant every cycle thereafter.

## Test plan
- Reset: hold rst=1 for 2 cycles with arbitrary opcode -> pc=0, acc=0, we=0. Release -> pc=1 after the first executed NOP.
- Load/add/store: dmem[0]=0003, dmem[1]=0005. Program: LD 0, ADD 1, ST 2, HALT -> dmem[2]=0008. Then pc stays at 3 and acc=0008 forever.
- SUB/logic/shift with acc=00F0 and dmem=000F:
  - SUB -> 00E1.
  - AND -> 0000.
  - OR -> 00FF.
  - XOR -> 00FF.
  - NOT of 00F0 -> FF0F.
  - SHL of 8001 -> 0002.
  - SHR of 8001 -> 4000.
- Wrap arithmetic: acc=FFFF, ADD of 0001 -> acc=0000. Then BEZ 10 -> pc=10. BNZ with acc=0 -> pc+1.
- Loop: LDI 3 at 0, SUB of dmem[5]=1 at 1, BNZ 1 at 2, HALT at 3 -> three passes through address 1, then pc=3 with acc=0.
- Reset mid-run: assert rst during an ST cycle -> no dmem write, pc=0 and acc=0 next cycle.
